// File: rtl/axis_uart_pkg.sv
// axis_uart_pkg: shared FSM encodings and baud timing helpers for axis_uart_link
package axis_uart_pkg;
   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP,
      S_GAP
   } uart_state_t;

   function automatic int clks_per_bit(input int clk_freq, input int baud);
      return clk_freq / baud;
   endfunction

   function automatic int baud_cnt_width(input int cpb);
      return $clog2(cpb);
   endfunction
endpackage

// File: rtl/axis_uart_sync_fifo.sv
// axis_uart_sync_fifo: synchronous FIFO with registered full/empty/count, no fall-through
module axis_uart_sync_fifo #(
   parameter int WIDTH = 9,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty,
   output logic [$clog2(DEPTH):0] count
);
   localparam int AW = $clog2(DEPTH);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0] wr_ptr, rd_ptr, count_n;
   logic wr, rd;
   assign wr = wr_en && !full;
   assign rd = rd_en && !empty;
   assign count_n = count + (AW+1)'(wr) - (AW+1)'(rd);
   assign rd_data = mem[rd_ptr[AW-1:0]];
   // full sits high during reset so the upstream sees no ready until the first clock after release
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         full   <= 1'b1;
         empty  <= 1'b1;
      end else begin
         wr_ptr <= wr_ptr + (AW+1)'(wr);
         rd_ptr <= rd_ptr + (AW+1)'(rd);
         count  <= count_n;
         full   <= count_n == (AW+1)'(DEPTH);
         empty  <= count_n == '0;
      end
   end
   always_ff @(posedge clk) begin
      if (wr) mem[wr_ptr[AW-1:0]] <= wr_data;
   end
endmodule

// File: rtl/axis_uart_link.sv
// axis_uart_link: full-duplex AXI-Stream <-> UART bridge with TX FIFO and sticky RX errors
// Optional parity bit and rx_parity_err port when AXIS_UART_PARITY_EN is defined.
module axis_uart_link
   import axis_uart_pkg::*;
#(
   parameter int DATA_BITS  = 8,
   parameter int FIFO_DEPTH = 8,
   parameter int CLK_FREQ   = 50000000,
   parameter int BAUD       = 115200,
   parameter int STOP_BITS  = 1,
   parameter int IDLE_GAP   = 2
`ifdef AXIS_UART_PARITY_EN
   , parameter bit PARITY_ODD = 1'b0
`endif
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [DATA_BITS-1:0] s_axis_tdata,
   input  logic                 s_axis_tvalid,
   input  logic                 s_axis_tlast,
   output logic                 s_axis_tready,
   output logic                 uart_tx,
   input  logic                 uart_rx,
   output logic [DATA_BITS-1:0] m_axis_tdata,
   output logic                 m_axis_tvalid,
   input  logic                 m_axis_tready,
   output logic                 tx_busy,
   output logic                 rx_frame_err,
   output logic                 rx_overrun,
   input  logic                 err_clr
`ifdef AXIS_UART_PARITY_EN
   , output logic               rx_parity_err
`endif
);
`ifdef AXIS_UART_PARITY_EN
   localparam bit PAR_EN = 1'b1;
`else
   localparam bit PAR_EN = 1'b0;
   localparam bit PARITY_ODD = 1'b0;
`endif
   localparam int CPB = clks_per_bit(CLK_FREQ, BAUD);
   localparam int CW = baud_cnt_width(CPB);
   localparam logic [CW-1:0] CPB_LAST = CW'(CPB - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(CPB / 2 - 1);

   logic fifo_full, fifo_empty, fifo_pop;
   logic [DATA_BITS:0] fifo_dout;
   logic [$clog2(FIFO_DEPTH):0] fifo_count;

   axis_uart_sync_fifo #(.WIDTH(DATA_BITS + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (s_axis_tvalid),
      .wr_data ({s_axis_tlast, s_axis_tdata}),
      .rd_en   (fifo_pop),
      .rd_data (fifo_dout),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   assign s_axis_tready = !fifo_full;

   uart_state_t tx_state, tx_state_n;
   logic [CW-1:0] tx_cnt;
   logic [7:0] tx_bit;
   logic [DATA_BITS-1:0] tx_shift;
   logic tx_last, tx_par, tx_line, tx_tick;
   assign tx_tick = tx_cnt == CPB_LAST;
   assign tx_busy = tx_state != S_IDLE || fifo_count != '0;

   always_comb begin
      tx_state_n = tx_state;
      fifo_pop = 1'b0;
      case (tx_state)
         S_IDLE: begin
            fifo_pop = !fifo_empty;
            tx_state_n = fifo_empty ? S_IDLE : S_START;
         end
         S_START:  tx_state_n = tx_tick ? S_DATA : S_START;
         S_DATA:   tx_state_n = (tx_tick && tx_bit == 8'(DATA_BITS - 1)) ? (PAR_EN ? S_PARITY : S_STOP) : S_DATA;
         S_PARITY: tx_state_n = tx_tick ? S_STOP : S_PARITY;
         S_STOP:   tx_state_n = !(tx_tick && tx_bit == 8'(STOP_BITS - 1)) ? S_STOP :
                                (tx_last && IDLE_GAP > 0) ? S_GAP : S_IDLE;
         S_GAP:    tx_state_n = (tx_tick && tx_bit == 8'(IDLE_GAP - 1)) ? S_IDLE : S_GAP;
         default:  tx_state_n = S_IDLE;
      endcase
      // line level is computed for the state being entered so uart_tx can be a plain register
      tx_line = tx_state_n == S_START ? 1'b0 :
                tx_state_n == S_DATA ? ((tx_state == S_DATA && tx_tick) ? tx_shift[1] : tx_shift[0]) :
                tx_state_n == S_PARITY ? tx_par : 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tx_state <= S_IDLE;
         tx_cnt   <= '0;
         tx_bit   <= '0;
         tx_shift <= '0;
         tx_last  <= 1'b0;
         tx_par   <= 1'b0;
         uart_tx  <= 1'b1;
      end else begin
         tx_state <= tx_state_n;
         tx_cnt   <= (tx_state_n != tx_state || tx_tick) ? '0 : tx_cnt + 1'b1;
         tx_bit   <= tx_state_n != tx_state ? '0 : tx_tick ? tx_bit + 1'b1 : tx_bit;
         uart_tx  <= tx_line;
         if (fifo_pop) begin
            tx_shift <= fifo_dout[DATA_BITS-1:0];
            tx_last  <= fifo_dout[DATA_BITS];
            tx_par   <= ^fifo_dout[DATA_BITS-1:0] ^ PARITY_ODD;
         end else if (tx_state == S_DATA && tx_tick) begin
            tx_shift <= tx_shift >> 1;
         end
      end
   end

   uart_state_t rx_state, rx_state_n;
   logic [CW-1:0] rx_cnt;
   logic [7:0] rx_bit;
   logic [DATA_BITS-1:0] rx_shift;
   logic rx_s1, rx_s2, rx_prev, rx_par_bad, rx_tick, rx_done, rx_good, out_free;
   assign rx_tick  = rx_cnt == CPB_LAST;
   assign rx_done  = rx_state == S_STOP && rx_tick;
   assign rx_good  = rx_done && rx_s2 && !rx_par_bad;
   assign out_free = !m_axis_tvalid || m_axis_tready;

   // GAP doubles as the wait-for-line-high state after a framing error
   always_comb begin
      rx_state_n = rx_state;
      case (rx_state)
         S_IDLE:   rx_state_n = (rx_prev && !rx_s2) ? S_START : S_IDLE;
         S_START:  rx_state_n = rx_cnt != HALF_LAST ? S_START : rx_s2 ? S_IDLE : S_DATA;
         S_DATA:   rx_state_n = (rx_tick && rx_bit == 8'(DATA_BITS - 1)) ? (PAR_EN ? S_PARITY : S_STOP) : S_DATA;
         S_PARITY: rx_state_n = rx_tick ? S_STOP : S_PARITY;
         S_STOP:   rx_state_n = !rx_tick ? S_STOP : rx_s2 ? S_IDLE : S_GAP;
         S_GAP:    rx_state_n = rx_s2 ? S_IDLE : S_GAP;
         default:  rx_state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rx_s1         <= 1'b1;
         rx_s2         <= 1'b1;
         rx_prev       <= 1'b1;
         rx_state      <= S_IDLE;
         rx_cnt        <= '0;
         rx_bit        <= '0;
         rx_shift      <= '0;
         rx_par_bad    <= 1'b0;
         m_axis_tdata  <= '0;
         m_axis_tvalid <= 1'b0;
         rx_frame_err  <= 1'b0;
         rx_overrun    <= 1'b0;
      end else begin
         rx_s1    <= uart_rx;
         rx_s2    <= rx_s1;
         rx_prev  <= rx_s2;
         rx_state <= rx_state_n;
         rx_cnt   <= (rx_state_n != rx_state || rx_tick) ? '0 : rx_cnt + 1'b1;
         rx_bit   <= rx_state_n != rx_state ? '0 : rx_tick ? rx_bit + 1'b1 : rx_bit;
         if (rx_state == S_DATA && rx_tick) rx_shift <= {rx_s2, rx_shift[DATA_BITS-1:1]};
         if (rx_state == S_PARITY && rx_tick) rx_par_bad <= rx_s2 != (^rx_shift ^ PARITY_ODD);
         if (rx_good && out_free) m_axis_tdata <= rx_shift;
         m_axis_tvalid <= (rx_good && out_free) || (m_axis_tvalid && !m_axis_tready);
         rx_frame_err  <= (rx_done && !rx_s2) || (rx_frame_err && !err_clr);
         rx_overrun    <= (rx_good && !out_free) || (rx_overrun && !err_clr);
      end
   end

`ifdef AXIS_UART_PARITY_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) rx_parity_err <= 1'b0;
      else rx_parity_err <= (rx_done && rx_s2 && rx_par_bad) || (rx_parity_err && !err_clr);
   end
`endif
endmodule
